// File: rtl/pr_timer_responder.sv
// pr_timer_responder
//   Memory-mapped programmable timer on the processor bus. It decodes a
//   16-byte window at BASE_ADDR, serves CPU reads combinationally, applies
//   CPU writes at posedge clk, counts down from PRESET and raises HWInt[0].
//
//   Register map (PrAddr[3:2]):
//     0x0 CTRL   [0] EN, [2:1] MODE (01 = auto-reload, else one-shot), [3] IM
//     0x4 PRESET reload value
//     0x8 COUNT  current count (read-only)
//     0xC        unmapped, reads 0
//
// Ports
//   clk     system clock
//   rst     asynchronous reset, active-low
//   PrAddr  CPU byte address (bits [1:0] ignored)
//   PrDOut  CPU write data
//   Wen     CPU write strobe
//   PrDIn   read data back to the CPU (combinational)
//   HWInt   interrupt lines; bit 0 is the timer, the rest are tied low
module pr_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          DEV_CNT   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        PrAddr,
  input  logic [31:0]        PrDOut,
  input  logic               Wen,
  output logic [31:0]        PrDIn,
  output logic [DEV_CNT-1:0] HWInt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_pending;
  logic        irq_set;
  logic        clr_en;

  // Address decode
  logic hit;
  logic wr_ctrl, wr_preset;
  logic unused_addr_bits;

  assign hit              = (PrAddr[31:4] == BASE_ADDR[31:4]);
  assign wr_ctrl          = Wen && hit && (PrAddr[3:2] == 2'd0);
  assign wr_preset        = Wen && hit && (PrAddr[3:2] == 2'd1);
  assign unused_addr_bits = ^PrAddr[1:0];

  logic en, mode_auto;
  assign en        = ctrl[0];
  assign mode_auto = (ctrl[2:1] == 2'b01);

  // Next-state / counter logic
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    irq_set   = 1'b0;
    clr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (en) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count <= 32'd1) begin
          // PRESET=0 and PRESET=1 both expire on the first CNT cycle.
          count_nxt = 32'd0;
          state_nxt = INT;
          irq_set   = !mode_auto;
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      INT: begin
        if (!mode_auto) begin
          state_nxt = IDLE;
          clr_en    = 1'b1;
        end else if (en) begin
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= 32'd0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // A CPU write to CTRL overrides the FSM's EN clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl <= 4'd0;
    end else if (wr_ctrl) begin
      ctrl <= PrDOut[3:0];
    end else if (clr_en) begin
      ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preset <= 32'd0;
    end else if (wr_preset) begin
      preset <= PrDOut;
    end
  end

  // Setting beats clearing so an expiry coinciding with a CTRL write is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_pending <= 1'b0;
    end else if (irq_set) begin
      irq_pending <= 1'b1;
    end else if (wr_ctrl) begin
      irq_pending <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    PrDIn = 32'd0;
    if (hit) begin
      case (PrAddr[3:2])
        2'd0:    PrDIn = {28'd0, ctrl};
        2'd1:    PrDIn = preset;
        2'd2:    PrDIn = count;
        default: PrDIn = 32'd0;
      endcase
    end
  end

  // Auto-reload gives a one-cycle pulse in INT; one-shot holds a level.
  always_comb begin
    HWInt    = '0;
    HWInt[0] = ctrl[3] && (irq_pending || ((state == INT) && mode_auto));
  end

endmodule

// File: tb/tb_pr_timer_responder.sv
module tb_pr_timer_responder;

  localparam logic [31:0] BASE    = 32'h0000_7F00;
  localparam int          DEV_CNT = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [31:0]        PrAddr = 32'd0;
  logic [31:0]        PrDOut = 32'd0;
  logic               Wen = 1'b0;
  logic [31:0]        PrDIn;
  logic [DEV_CNT-1:0] HWInt;

  pr_timer_responder #(.BASE_ADDR(BASE), .DEV_CNT(DEV_CNT)) dut (
    .clk   (clk),
    .rst   (rst),
    .PrAddr(PrAddr),
    .PrDOut(PrDOut),
    .Wen   (Wen),
    .PrDIn (PrDIn),
    .HWInt (HWInt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: timer phase 0=idle, 1=loading, 2=counting, 3=expired.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  bit          m_pend;
  int          m_phase;

  function automatic void m_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_pend = 0; m_phase = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    if (a[3:2] == 2'd0) return {28'd0, m_ctrl};
    if (a[3:2] == 2'd1) return m_preset;
    if (a[3:2] == 2'd2) return m_count;
    return 32'd0;
  endfunction

  function automatic bit m_int();
    bit autorl = (m_ctrl[2:1] == 2'b01);
    return m_ctrl[3] && (m_pend || (m_phase == 3 && autorl));
  endfunction

  function automatic void m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit          autorl = (m_ctrl[2:1] == 2'b01);
    bit          enb    = m_ctrl[0];
    bit          fire   = 0;
    int          ph     = m_phase;
    logic [31:0] cnt    = m_count;
    logic [3:0]  ctl    = m_ctrl;
    bit          hitw   = w && (a[31:4] == BASE[31:4]);
    if (m_phase == 0) begin
      if (enb) ph = 1;
    end else if (m_phase == 1) begin
      cnt = m_preset; ph = 2;
    end else if (m_phase == 2) begin
      if (!enb) ph = 0;
      else if (m_count == 0 || m_count == 1) begin
        cnt = 0; ph = 3; fire = !autorl;
      end else cnt = m_count - 1;
    end else begin
      if (!autorl) begin ph = 0; ctl[0] = 1'b0; end
      else ph = enb ? 1 : 0;
    end
    if (hitw && a[3:2] == 2'd0) begin
      ctl = d[3:0];
      m_pend = fire;
    end else begin
      m_pend = m_pend | fire;
    end
    if (hitw && a[3:2] == 2'd1) m_preset = d;
    m_ctrl = ctl; m_count = cnt; m_phase = ph;
  endfunction

  logic [31:0]        obs_rd;
  logic [DEV_CNT-1:0] obs_int;

  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Wen = w; PrAddr = a; PrDOut = d;
    #1;
    obs_rd  = PrDIn;
    obs_int = HWInt;
    check("rd", PrDIn, m_read(a));
    check("hwint", 32'(HWInt), {31'd0, m_int()});
    @(posedge clk);
    if (rst) m_step(w, a, d);
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    #1 rst = 1'b0; Wen = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      PrAddr = BASE + 32'(4 * i);
      #1 check("rst_rd", PrDIn, 32'd0);
    end
    check("rst_int", 32'(HWInt), 32'd0);
    repeat (n) cycle(1'b0, BASE + 32'd8, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PrAddr = BASE + 32'(4 * i);
      #1 check("post_rst_rd", PrDIn, 32'd0);
    end
  endtask

  task automatic wait_int(input int maxj, output int jfound);
    jfound = -1;
    for (int j = 1; j <= maxj; j++) begin
      cycle(1'b0, BASE + 32'd8, 32'd0);
      if (obs_int[0] && jfound < 0) begin
        jfound = j;
        break;
      end
    end
  endtask

  logic [31:0] addrs [8];

  initial begin
    int          jf, r, t_prev, period, npulse, highs;
    logic [31:0] ra, rd;

    addrs[0] = BASE;          addrs[1] = BASE + 32'h4;
    addrs[2] = BASE + 32'h8;  addrs[3] = BASE + 32'hC;
    addrs[4] = BASE + 32'h10; addrs[5] = BASE + 32'h5;
    addrs[6] = BASE + 32'h1;  addrs[7] = BASE - 32'h4;

    m_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Level interrupt in one-shot mode
    cycle(1'b1, BASE + 32'h4, 32'd5);
    cycle(1'b1, BASE, 32'h9);
    wait_int(12, jf);
    check("t2_latency", jf - 1, 7);
    check("t2_count", obs_rd, 32'd0);
    cycle(1'b0, BASE, 32'd0);
    check("t2_ctrl", obs_rd, 32'h8);
    check("t2_held", 32'(obs_int[0]), 32'd1);
    cycle(1'b1, BASE, 32'h8);
    cycle(1'b0, BASE, 32'd0);
    check("t2_clear", 32'(obs_int[0]), 32'd0);

    // Mid-run reset
    pulse_reset(3);

    // Auto-reload pulses, then a shorter PRESET
    cycle(1'b1, BASE + 32'h4, 32'd3);
    cycle(1'b1, BASE, 32'hB);
    t_prev = -1; period = 0; npulse = 0;
    for (int j = 1; j <= 20; j++) begin
      cycle(1'b0, BASE + 32'h8, 32'd0);
      if (obs_int[0]) begin
        if (t_prev >= 0) period = j - t_prev;
        t_prev = j; npulse++;
      end
    end
    check("t3_period", period, 5);
    check("t3_npulse", npulse, 3);
    cycle(1'b1, BASE + 32'h4, 32'd1);
    t_prev = -1; period = 0;
    for (int j = 1; j <= 15; j++) begin
      cycle(1'b0, BASE + 32'h8, 32'd0);
      if (obs_int[0]) begin
        if (t_prev >= 0) period = j - t_prev;
        t_prev = j;
      end
    end
    check("t3_period_short", period, 3);

    // Masked interrupt, then unmask and restart
    pulse_reset(1);
    cycle(1'b1, BASE + 32'h4, 32'd4);
    cycle(1'b1, BASE, 32'h1);
    highs = 0;
    for (int j = 0; j < 12; j++) begin
      cycle(1'b0, BASE + 32'h8, 32'd0);
      if (obs_int[0]) highs++;
    end
    check("t4_masked", highs, 0);
    check("t4_count", obs_rd, 32'd0);
    cycle(1'b1, BASE, 32'h9);
    wait_int(12, jf);
    check("t4_latency", jf - 1, 6);

    // Disable mid-count holds COUNT, re-enable reloads
    pulse_reset(1);
    cycle(1'b1, BASE + 32'h4, 32'd4);
    cycle(1'b1, BASE, 32'h9);
    repeat (3) cycle(1'b0, BASE + 32'h8, 32'd0);
    cycle(1'b1, BASE, 32'h8);
    repeat (3) cycle(1'b0, BASE + 32'h8, 32'd0);
    check("t5_hold", obs_rd, 32'd2);
    cycle(1'b1, BASE, 32'h9);
    repeat (3) cycle(1'b0, BASE + 32'h8, 32'd0);
    check("t5_reload", obs_rd, 32'd4);

    // Ignored writes and decode
    pulse_reset(1);
    cycle(1'b1, BASE + 32'h4, 32'h1234);
    cycle(1'b1, BASE, 32'h6);
    cycle(1'b1, BASE + 32'hC, 32'hFFFF_FFFF);
    cycle(1'b1, BASE + 32'h8, 32'hFFFF_FFFF);
    cycle(1'b1, BASE + 32'h10, 32'hFFFF_FFFF);
    cycle(1'b0, BASE, 32'd0);        check("t6_ctrl", obs_rd, 32'h6);
    cycle(1'b0, BASE + 32'h4, 32'd0); check("t6_preset", obs_rd, 32'h1234);
    cycle(1'b0, BASE + 32'h8, 32'd0); check("t6_count", obs_rd, 32'd0);
    cycle(1'b0, BASE + 32'hC, 32'd0); check("t6_unmapped", obs_rd, 32'd0);
    cycle(1'b0, BASE + 32'h10, 32'd0); check("t6_miss", obs_rd, 32'd0);
    cycle(1'b0, BASE + 32'h5, 32'd0); check("t6_offset5", obs_rd, 32'h1234);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      r  = $urandom_range(99);
      ra = addrs[$urandom_range(7)];
      rd = $urandom;
      if (ra[3:2] == 2'd1) rd = 32'($urandom_range(7));
      if (r < 2)       pulse_reset(1 + $urandom_range(2));
      else if (r < 55) cycle(1'b0, ra, rd);
      else             cycle(1'b1, ra, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pr_timer_responder.md
Name: pr_timer_responder

Overview:
- Memory-mapped programmable timer that answers the CPU's processor-bus requests (PrAddr/PrDOut/Wen) and returns read data on PrDIn.
- It is the device end of the bus that the mips core drives.
- It raises a hardware interrupt on HWInt for CP0.
- It sits beside mips at system top level; HWInt[0] is the timer line and all other HWInt bits are driven 0.

Parameters:
- BASE_ADDR, 32'h0000_7F00, base of the 16-byte register window; bits [3:0] must be 0.
- DEV_CNT, 6, width of HWInt; equals the CP0 device count.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low. rst=0 resets immediately, independent of clk.
- PrAddr  in  32  CPU byte address.
- PrDOut  in  32  CPU write data.
- Wen  in  1  CPU write strobe; sampled at posedge clk.
- PrDIn  out  32  read data to CPU; combinational from PrAddr and the registers.
- HWInt  out  DEV_CNT  interrupt lines. Bit 0 is the timer interrupt; bits [DEV_CNT-1:1] are constant 0.

Behaviour:
- Decode:
  - A hit requires PrAddr[31:4]==BASE_ADDR[31:4]. PrAddr[1:0] are ignored.
  - Offset 0x0 = CTRL, 0x4 = PRESET, 0x8 = COUNT (read-only), 0xC = unmapped.
- Reads: PrDIn is {28'b0,CTRL[3:0]}, PRESET or COUNT for the selected register. It is 0 for 0xC or a miss. There is no read side effect.
- Writes: applied at posedge when Wen=1 and the address hits.
  - A CTRL write stores PrDOut[3:0] and clears irq_pending.
  - A PRESET write stores PrDOut.
  - Writes to COUNT or 0xC, and missed writes, are ignored.
- CTRL fields:
  - [0] EN.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload, 10/11 behave as 00.
  - [3] IM, interrupt mask (1 = enabled).
- Reset values: CTRL=0, PRESET=0, COUNT=0, irq_pending=0, state=IDLE, HWInt=0, PrDIn=0 for any address.
- FSM states IDLE, LOAD, CNT, INT; transitions at posedge:
  - IDLE: EN=1 -> LOAD; else stay in IDLE.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT:
    - EN=0 -> IDLE; COUNT holds.
    - Else COUNT<=1 -> COUNT<=0, go to INT; irq_pending<=1 if MODE is one-shot.
    - Else COUNT<=COUNT-1.
  - INT:
    - One-shot -> IDLE with CTRL.EN<=0.
    - Auto-reload -> LOAD.
- Interrupt output:
  - HWInt[0] = IM & (irq_pending | (state==INT && MODE==01)).
  - One-shot: a level interrupt held until a CTRL write.
  - Auto-reload: a one-cycle pulse per period.
- Latency: with PRESET=N and EN written at edge k, the state reaches INT at edge k+2+N for N>=1. For N=0 it reaches INT at edge k+3.
- Auto-reload period is N+2 cycles (N>=1).
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as an FSM update of CTRL.EN wins; the whole CTRL value comes from PrDOut.
  - A CTRL write in the same cycle as irq_pending being set leaves irq_pending=1 (the set wins). This avoids losing an interrupt.
  - A PRESET write during CNT does not change the running COUNT; it takes effect at the next LOAD.
  - Clearing EN during LOAD/INT: LOAD completes to CNT, then CNT sees EN=0 -> IDLE. In INT, auto-reload goes to IDLE instead of LOAD if EN=0.
- Reset mid-count: asserting rst forces all reset values immediately (async). Counting resumes only after EN is rewritten.

Test Plan:
1. Reset -> rst=0 for 3 cycles mid-run -> HWInt=0 and PrDIn=0 at offsets 0x0/0x4/0x8 while rst=0 and after release.
2. Write PRESET=5, then CTRL=0x9 at edge k -> HWInt[0]=0 until edge k+7, then 1. COUNT reads 0. CTRL reads 0x8 from edge k+8. HWInt stays 1 until a CTRL write of 0x8, then drops at that edge.
3. PRESET=3, CTRL=0xB (auto-reload, IM) -> HWInt[0] is a 1-cycle pulse every 5 cycles. COUNT reads 3,2,1,0 between pulses. A PRESET=1 write mid-count gives a 3-cycle period starting after the next LOAD.
4. PRESET=4, CTRL=0x1 (IM=0) -> HWInt stays 0 throughout, yet COUNT reaches 0. A later CTRL=0x9 write clears pending and restarts; interrupt 6 cycles later.
5. Write CTRL=0x9 then CTRL=0x8 while COUNT=2 -> FSM goes to IDLE and COUNT holds 2. Write CTRL=0x9 again -> reload from PRESET.
6. Write to BASE_ADDR+0xC, BASE_ADDR+0x8, and BASE_ADDR+0x10 (miss) with PrDOut=32'hFFFF_FFFF -> no register changes. Reads of 0xC/miss return 0. PrAddr=BASE_ADDR+0x5 reads PRESET.
